// File: rtl/regfile_pkg.sv
// Shared constants for the integer register file.
// X31 is hardwired to zero.
package regfile_pkg;

   localparam int DATA_WIDTH = 64;
   localparam int ADDR_WIDTH = 5;
   localparam int NUM_REGS   = 32;

   localparam logic [ADDR_WIDTH-1:0] ZERO_REG = 5'd31;

endpackage

// File: rtl/regfile_if.sv
// Register file access bus: one write port, two read ports.
// master drives addresses/data, slave returns read data.
interface regfile_if #(
   parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH
);
   import regfile_pkg::*;

   logic                  RegWrite;
   logic [ADDR_WIDTH-1:0] WriteRegister;
   logic [DATA_WIDTH-1:0] WriteData;
   logic [ADDR_WIDTH-1:0] ReadRegister1;
   logic [ADDR_WIDTH-1:0] ReadRegister2;
   logic [DATA_WIDTH-1:0] ReadData1;
   logic [DATA_WIDTH-1:0] ReadData2;

   modport master (
      output RegWrite,
      output WriteRegister,
      output WriteData,
      output ReadRegister1,
      output ReadRegister2,
      input  ReadData1,
      input  ReadData2
   );

   modport slave (
      input  RegWrite,
      input  WriteRegister,
      input  WriteData,
      input  ReadRegister1,
      input  ReadRegister2,
      output ReadData1,
      output ReadData2
   );

endinterface

// File: rtl/regfile_en_register.sv
// Single storage word: enable-gated load, async active-high clear.
module en_register #(
   parameter int WIDTH = regfile_pkg::DATA_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/regfile.sv
// Two-read/one-write register file, X31 reads zero,
// with same-cycle write-to-read bypass on both ports.
module regfile #(
   parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
   parameter int NUM_REGS   = regfile_pkg::NUM_REGS
) (
   input logic       clk,
   input logic       reset,
   regfile_if.slave  bus
);
   import regfile_pkg::*;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [NUM_REGS-1:0]   we;
   logic                  wr_live;
   logic [DATA_WIDTH-1:0] rd1;
   logic [DATA_WIDTH-1:0] rd2;

   // Reset and the zero register both kill the write before decode.
   assign wr_live = bus.RegWrite && !reset
                 && (bus.WriteRegister != ZERO_REG);

   always_comb begin
      we = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (wr_live && bus.WriteRegister == ADDR_WIDTH'(i)) begin
            we[i] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      en_register #(
         .WIDTH (DATA_WIDTH)
      ) u_reg (
         .clk   (clk),
         .reset (reset),
         .en    (we[g]),
         .d     (bus.WriteData),
         .q     (regs[g])
      );
   end

   always_comb begin
      rd1 = regs[bus.ReadRegister1];
      if (bus.ReadRegister1 == ZERO_REG) begin
         rd1 = '0;
      end else if (wr_live
                && bus.WriteRegister == bus.ReadRegister1) begin
         rd1 = bus.WriteData;
      end
   end

   always_comb begin
      rd2 = regs[bus.ReadRegister2];
      if (bus.ReadRegister2 == ZERO_REG) begin
         rd2 = '0;
      end else if (wr_live
                && bus.WriteRegister == bus.ReadRegister2) begin
         rd2 = bus.WriteData;
      end
   end

   assign bus.ReadData1 = rd1;
   assign bus.ReadData2 = rd2;

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001: Parameter DATA_WIDTH, default 64, is the width of each register and each data port.
REQ-002: Parameter NUM_REGS, default 32, is the number of architectural registers; address width is log2(NUM_REGS) = 5.
REQ-003: clk  input  1  is the single clock; all register state updates on its rising edge.
REQ-004: reset  input  1  is an asynchronous, active-high reset.
REQ-005: RegWrite  input  1  is the write enable for the current cycle.
REQ-006: WriteRegister  input  5  is the destination register address.
REQ-007: WriteData  input  DATA_WIDTH  is the value to write.
REQ-008: ReadRegister1  input  5  is the read port 1 address.
REQ-009: ReadRegister2  input  5  is the read port 2 address.
REQ-010: ReadData1  output  DATA_WIDTH  is the read port 1 data.
REQ-011: ReadData2  output  DATA_WIDTH  is the read port 2 data.

Function
REQ-012: Storage SHALL consist of NUM_REGS registers X0..X31, each DATA_WIDTH bits.
REQ-013: At the rising edge of clk with RegWrite=1 and reset=0, register[WriteRegister] SHALL take the value of WriteData; all other registers SHALL hold.
REQ-014: With RegWrite=0, no register SHALL change.
REQ-015: Register X31 is the zero register: writes to address 31 SHALL be discarded, and reads of address 31 SHALL return 0 on both ports.
REQ-016: Reads SHALL be combinational: ReadDataN SHALL equal register[ReadRegisterN] within the same cycle, with zero clock latency.
REQ-017: Write-to-read bypass: when RegWrite=1, WriteRegister!=31 and WriteRegister==ReadRegisterN, ReadDataN SHALL equal WriteData in that same cycle, before the clock edge.
REQ-018: Both ports SHALL bypass independently; when both address the written register, both SHALL return WriteData.
REQ-019: Both read ports reading the same address SHALL return identical data.
REQ-020: A write to address 31 SHALL NOT trigger the bypass; reads of 31 SHALL remain 0.
REQ-021: Each write SHALL affect exactly one register; no other register SHALL be corrupted, including adjacent addresses.

Reset
REQ-022: Assertion of reset SHALL clear all registers to 0 immediately, independent of clk.
REQ-023: While reset=1, writes SHALL be ignored and both ReadData outputs SHALL reflect register contents of 0.
REQ-024: While reset=1, the bypass path SHALL be suppressed, so ReadData1 and ReadData2 read 0.
REQ-025: A write on the first rising edge after reset deasserts SHALL take effect normally.
REQ-026: Reset asserted while a write is pending in a cycle SHALL win; the target register SHALL read 0.

Structure
REQ-027: A shared package regfile_pkg SHALL hold DATA_WIDTH, ADDR_WIDTH=5, NUM_REGS=32 and ZERO_REG=5'd31.
REQ-028: Each storage word SHALL be an instance of a single sub-module en_register, a DATA_WIDTH-bit register with asynchronous active-high reset and write enable.
REQ-029: A 5-to-32 one-hot write-enable decoder gated by RegWrite, a NUM_REGS:1 read mux per port, and the bypass compare SHALL live in regfile itself.

Verification
REQ-030: Reset, then read all addresses on both ports -> every ReadData=0.
REQ-031: Write X5=64'hDEADBEEF_CAFEF00D, then read ReadRegister1=5 next cycle -> ReadData1=64'hDEADBEEF_CAFEF00D; X4 and X6 read 0.
REQ-032: RegWrite=1, WriteRegister=31, WriteData=64'hFFFF_FFFF_FFFF_FFFF, ReadRegister1=ReadRegister2=31 -> both ports read 0 in that cycle and afterwards.
REQ-033: Same-cycle bypass: X7 holds 1; RegWrite=1, WriteRegister=7, WriteData=64'd42, ReadRegister1=7 -> ReadData1=42 before the edge, and still 42 after it.
REQ-034: Write X0..X30 with value equal to address*3 over 31 cycles, then read pairs (n, 30-n) -> ReadData1=3n and ReadData2=3(30-n).
REQ-035: Assert reset mid-cycle between edges after X9=64'd77 -> ReadData for address 9 drops to 0 without a clock edge; RegWrite=1 during reset leaves X9 at 0.
